execute_pipe: RTL and testbench

EXECUTE_PIPE -- requirements
Module: execute_pipe

---
 rtl/execute_pipe_if.sv | 29 ++
 rtl/execute_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_execute_pipe.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/execute_pipe_if.sv
// rtl/execute_pipe_if.sv - operation/result handshake bundle for execute_pipe
interface execute_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [WIDTH-1:0] imm;
  logic [6:0]       control_in;
  logic [WIDTH-1:0] mem_data_read_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] aluout;
  logic             carry;
  logic [WIDTH-1:0] mem_data_write_out;
  logic             mem_write_en;
  logic             busy;

  modport master (
    output in_valid, src1, src2, imm, control_in, mem_data_read_in, out_ready,
    input  in_ready, out_valid, aluout, carry, mem_data_write_out, mem_write_en, busy
  );

  modport slave (
    input  in_valid, src1, src2, imm, control_in, mem_data_read_in, out_ready,
    output in_ready, out_valid, aluout, carry, mem_data_write_out, mem_write_en, busy
  );
endinterface

// File: rtl/execute_pipe.sv
// rtl/execute_pipe.sv - single-issue execute stage with latency-1 ALU and iterative multiplier
module execute_pipe #(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           enable_ex,
  execute_pipe_if.slave  bus
);
  localparam int LW     = $clog2(WIDTH);
  localparam bit MUL_ON = (MUL_EN != 0);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t state, state_next;

  logic               out_valid_q;
  logic [WIDTH-1:0]   aluout_q;
  logic               carry_q;
  logic [WIDTH-1:0]   mdw_q;
  logic               mw_q;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [LW-1:0]      cnt;
  logic [WIDTH-1:0]   mul_src2;
  logic               mul_mw;

  logic [WIDTH-1:0]   opb;
  logic [1:0]         cls;
  logic [2:0]         op;
  logic [LW-1:0]      shamt;
  logic               is_mul;
  logic               accept;
  logic               mul_done;
  logic               busy_int;
  logic [2*WIDTH-1:0] acc_next;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] sh;

  assign opb      = bus.control_in[6] ? bus.imm : bus.src2;
  assign cls      = bus.control_in[5:4];
  assign op       = bus.control_in[3:1];
  assign shamt    = opb[LW-1:0];
  assign is_mul   = MUL_ON && (cls == 2'b11);
  assign accept   = bus.in_valid & bus.in_ready;
  assign mul_done = (state == S_MUL) && (cnt == LW'(WIDTH - 1));
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // reset is folded in so nothing is offered as accepted while held in reset
  assign bus.in_ready = reset & enable_ex & ~busy_int & (~out_valid_q | bus.out_ready);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    sum     = '0;
    sh      = '0;
    case (cls)
      2'b00: begin
        case (op)
          3'b000: begin
            sum     = {1'b0, bus.src1} + {1'b0, opb};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
          end
          3'b001: begin
            sum     = {1'b0, bus.src1} - {1'b0, opb};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
          end
          3'b010: begin
            sum     = {1'b0, bus.src1} + {{WIDTH{1'b0}}, 1'b1};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
          end
          3'b011:  alu_res = opb;
          3'b100:  alu_res = bus.mem_data_read_in;
          default: alu_res = '0;
        endcase
      end
      2'b01: begin
        case (op)
          3'b000:  alu_res = bus.src1 & opb;
          3'b001:  alu_res = bus.src1 | opb;
          3'b010:  alu_res = bus.src1 ^ opb;
          3'b011:  alu_res = ~bus.src1;
          default: alu_res = '0;
        endcase
      end
      2'b10: begin
        // double-width shifts leave the last shifted-out bit at the word boundary
        case (op)
          3'b000: begin
            sh      = {{WIDTH{1'b0}}, bus.src1} << shamt;
            alu_res = sh[WIDTH-1:0];
            alu_c   = sh[WIDTH];
          end
          3'b001: begin
            sh      = {bus.src1, {WIDTH{1'b0}}} >> shamt;
            alu_res = sh[2*WIDTH-1:WIDTH];
            alu_c   = sh[WIDTH-1];
          end
          3'b010: begin
            sh      = $signed({bus.src1, {WIDTH{1'b0}}}) >>> shamt;
            alu_res = sh[2*WIDTH-1:WIDTH];
            alu_c   = sh[WIDTH-1];
          end
          3'b011: begin
            sh      = {bus.src1, bus.src1} << shamt;
            alu_res = sh[2*WIDTH-1:WIDTH];
          end
          default: alu_res = '0;
        endcase
      end
      default: alu_res = MUL_ON ? '0 : bus.src1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
    end else if (enable_ex) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept && is_mul) state_next = S_MUL;
      S_MUL:   if (mul_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_int = (state == S_MUL);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      aluout_q    <= '0;
      carry_q     <= 1'b0;
      mdw_q       <= '0;
      mw_q        <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      cnt         <= '0;
      mul_src2    <= '0;
      mul_mw      <= 1'b0;
    end else begin
      // a downstream transfer completes even while the stage is frozen
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (enable_ex) begin
        if (accept && !is_mul) begin
          out_valid_q <= 1'b1;
          aluout_q    <= alu_res;
          carry_q     <= alu_c;
          mdw_q       <= bus.src2;
          mw_q        <= bus.control_in[0];
        end else if (accept && is_mul) begin
          acc      <= '0;
          mcand    <= {{WIDTH{1'b0}}, bus.src1};
          mplier   <= opb;
          cnt      <= '0;
          mul_src2 <= bus.src2;
          mul_mw   <= bus.control_in[0];
        end
        if (state == S_MUL) begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (mul_done) begin
            cnt         <= '0;
            out_valid_q <= 1'b1;
            aluout_q    <= acc_next[WIDTH-1:0];
            carry_q     <= |acc_next[2*WIDTH-1:WIDTH];
            mdw_q       <= mul_src2;
            mw_q        <= mul_mw;
          end
        end
      end
    end
  end

  assign bus.out_valid          = out_valid_q;
  assign bus.aluout             = aluout_q;
  assign bus.carry              = carry_q;
  assign bus.mem_data_write_out = mdw_q;
  assign bus.mem_write_en       = out_valid_q & mw_q;
  assign bus.busy               = busy_int;
endmodule

// File: tb/tb_execute_pipe.sv
// tb/tb_execute_pipe.sv - directed self-checking bench for execute_pipe
module tb_execute_pipe;
  logic clock = 1'b0;
  logic reset;
  logic enable_ex;
  int   nvec = 0;
  int   nerr = 0;

  execute_pipe_if #(.WIDTH(16)) bus ();

  execute_pipe #(.WIDTH(16), .MUL_EN(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable_ex (enable_ex),
    .bus       (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ctl(input bit isel, input logic [1:0] c, input logic [2:0] o, input bit mw);
    return {isel, c, o, mw};
  endfunction

  task automatic offer(input logic [6:0] c, input logic [15:0] a, input logic [15:0] b, input logic [15:0] i);
    bus.control_in = c;
    bus.src1       = a;
    bus.src2       = b;
    bus.imm        = i;
    bus.in_valid   = 1'b1;
  endtask

  task automatic one_op(input string tag, input logic [6:0] c, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] i,
                        input logic [15:0] er, input logic ec);
    offer(c, a, b, i);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_res"},   32'(bus.aluout),    32'(er));
    chk({tag, "_carry"}, 32'(bus.carry),     32'(ec));
  endtask

  logic [15:0] s_a  [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] s_b  [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
  logic [15:0] s_ex [4] = '{16'h1112, 16'h2224, 16'h3336, 16'h4448};

  initial begin
    int k, r;
    logic fin, fout;
    reset = 1'b0;
    enable_ex = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.src1 = '0; bus.src2 = '0; bus.imm = '0;
    bus.control_in = '0;
    bus.mem_data_read_in = 16'hBEEF;
    tick();
    tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_aluout", 32'(bus.aluout), 32'd0);
    chk("rst_carry", 32'(bus.carry), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mwe", 32'(bus.mem_write_en), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    one_op("add_ovf", ctl(0, 2'b00, 3'b000, 0), 16'hFFFF, 16'h0001, 16'h0, 16'h0000, 1'b1);
    tick();
    chk("add_drain", 32'(bus.out_valid), 32'd0);
    one_op("sub_imm", ctl(1, 2'b00, 3'b001, 0), 16'h0003, 16'h0000, 16'h0005, 16'hFFFE, 1'b1);
    one_op("sra1", ctl(0, 2'b10, 3'b010, 0), 16'h8001, 16'h0001, 16'h0, 16'hC000, 1'b1);
    one_op("sll0", ctl(0, 2'b10, 3'b000, 0), 16'h8001, 16'h0000, 16'h0, 16'h8001, 1'b0);
    one_op("srl1", ctl(0, 2'b10, 3'b001, 0), 16'h8001, 16'h0001, 16'h0, 16'h4000, 1'b1);
    one_op("rol4", ctl(0, 2'b10, 3'b011, 0), 16'h8001, 16'h0004, 16'h0, 16'h0018, 1'b0);
    one_op("xor", ctl(0, 2'b01, 3'b010, 0), 16'hF0F0, 16'hFF00, 16'h0, 16'h0FF0, 1'b0);
    one_op("not", ctl(0, 2'b01, 3'b011, 0), 16'h1234, 16'h0000, 16'h0, 16'hEDCB, 1'b0);
    one_op("load", ctl(0, 2'b00, 3'b100, 0), 16'h1234, 16'h5678, 16'h0, 16'hBEEF, 1'b0);
    one_op("undef", ctl(0, 2'b00, 3'b111, 0), 16'h1234, 16'h5678, 16'h0, 16'h0000, 1'b0);
    tick();

    offer(ctl(0, 2'b11, 3'b000, 0), 16'h0100, 16'h0100, 16'h0);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("mul_busy%0d", i), 32'(bus.busy), 32'd1);
      chk($sformatf("mul_rdy%0d", i), 32'(bus.in_ready), 32'd0);
      chk($sformatf("mul_ov%0d", i), 32'(bus.out_valid), 32'd0);
      tick();
    end
    chk("mul_valid", 32'(bus.out_valid), 32'd1);
    chk("mul_res", 32'(bus.aluout), 32'h0000);
    chk("mul_carry", 32'(bus.carry), 32'd1);
    chk("mul_busy_end", 32'(bus.busy), 32'd0);
    tick();

    offer(ctl(0, 2'b11, 3'b000, 1), 16'h0003, 16'h0005, 16'h0);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    enable_ex = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("frz_busy", 32'(bus.busy), 32'd1);
    chk("frz_rdy", 32'(bus.in_ready), 32'd0);
    enable_ex = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("frz_not_yet", 32'(bus.out_valid), 32'd0);
    tick();
    chk("frz_valid", 32'(bus.out_valid), 32'd1);
    chk("frz_res", 32'(bus.aluout), 32'h000F);
    chk("frz_carry", 32'(bus.carry), 32'd0);
    chk("frz_mwe", 32'(bus.mem_write_en), 32'd1);
    chk("frz_mdw", 32'(bus.mem_data_write_out), 32'h0005);
    tick();

    k = 0;
    r = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.out_valid) begin
        chk($sformatf("str_res%0d", r), 32'(bus.aluout), 32'(s_ex[r]));
        chk($sformatf("str_mwe%0d", r), 32'(bus.mem_write_en), 32'(r == 1));
        chk($sformatf("str_mdw%0d", r), 32'(bus.mem_data_write_out), 32'(s_b[r]));
      end
      bus.out_ready = !(c >= 2 && c <= 4);
      if (k < 4) offer(ctl(0, 2'b00, 3'b000, k == 1), s_a[k], s_b[k], 16'h0);
      else bus.in_valid = 1'b0;
      #1;
      fin  = bus.in_valid & bus.in_ready;
      fout = bus.out_valid & bus.out_ready;
      @(posedge clock);
      #1;
      if (fin) k++;
      if (fout && r < 4) r++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("str_accepted", 32'(k), 32'd4);
    chk("str_delivered", 32'(r), 32'd4);

    offer(ctl(0, 2'b11, 3'b000, 0), 16'h1234, 16'h0010, 16'h0);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b0;
    tick();
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_rdy", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("abort_rel_rdy", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 20; i++) tick();
    chk("abort_no_result", 32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
